// File: rtl/board_frame_renderer.sv
// board_frame_renderer
// Streams one RGB565 pixel per accepted handshake to the LT24 display, scanning
// the panel raster left-to-right, top-to-bottom. Each frame shows either the start
// screen or the play view. The play view has a clock banner at the top, the same
// banner rotated 180 degrees at the bottom, and an NxN board in between whose
// pieces come from an external synchronous sprite ROM. Cursor and selection
// outlines are drawn over the board.
//
// Ports
//   clock, reset           system clock, synchronous active-high reset
//   play_req               1 = play view wanted, 0 = start screen (taken at frame start)
//   board                  per square {colour, kind[2:0]}, square s at [4s+:4]
//   cursor_sq, select_sq   square indices (row*N+col); select_vld enables selection outline
//   rom_en, rom_addr       sprite ROM read strobe/address; rom_rdata valid one cycle later
//   xAddr, yAddr           coordinate of the pixel on pixelData
//   pixelData, pixelWrite  pixel and its valid; accepted when pixelWrite && pixelReady
//   pixelReady             display back-pressure
//   play_active            view used by the frame in flight
//   frame_done             one-cycle pulse after the last pixel of a frame is accepted
module board_frame_renderer #(
    parameter int          LCD_W       = 240,
    parameter int          LCD_H       = 320,
    parameter int          BANNER_H    = 40,
    parameter int          BOARD_N     = 8,
    parameter int          SQ          = 30,
    parameter int          KINDS       = 6,
    parameter int          HL_W        = 2,
    parameter int          ADDR_W      = 17,
    parameter int          START_BASE  = 0,
    parameter int          BANNER_BASE = 76800,
    parameter int          PIECE_BASE  = 86400,
    parameter logic [15:0] LIGHT_COL   = 16'hEF9B,
    parameter logic [15:0] DARK_COL    = 16'h7A69,
    parameter logic [15:0] CURSOR_COL  = 16'h07E0,
    parameter logic [15:0] SELECT_COL  = 16'hF800
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 play_req,
    input  logic [BOARD_N*BOARD_N*4-1:0]         board,
    input  logic [$clog2(BOARD_N*BOARD_N)-1:0]   cursor_sq,
    input  logic [$clog2(BOARD_N*BOARD_N)-1:0]   select_sq,
    input  logic                                 select_vld,
    output logic                                 rom_en,
    output logic [ADDR_W-1:0]                    rom_addr,
    input  logic [15:0]                          rom_rdata,
    output logic [$clog2(LCD_W)-1:0]             xAddr,
    output logic [$clog2(LCD_H)-1:0]             yAddr,
    output logic [15:0]                          pixelData,
    output logic                                 pixelWrite,
    input  logic                                 pixelReady,
    output logic                                 play_active,
    output logic                                 frame_done
);

    localparam int XW = $clog2(LCD_W);
    localparam int YW = $clog2(LCD_H);
    localparam int SW = $clog2(BOARD_N*BOARD_N);
    localparam int LW = $clog2(SQ);

    localparam logic [XW-1:0] X_LAST    = XW'(LCD_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(LCD_H - 1);
    localparam logic [YW-1:0] Y_TOP_END = YW'(BANNER_H - 1);
    localparam logic [YW-1:0] Y_BRD0    = YW'(BANNER_H);
    localparam logic [YW-1:0] Y_BRD_END = YW'(BANNER_H + BOARD_N*SQ);
    localparam logic [YW-1:0] Y_BOT     = YW'(LCD_H - BANNER_H);
    localparam logic [XW-1:0] COL_N     = XW'(BOARD_N);
    localparam logic [LW-1:0] SQ_LAST   = LW'(SQ - 1);
    localparam logic [LW-1:0] HL_LO     = LW'(HL_W);
    localparam logic [LW-1:0] HL_HI     = LW'(SQ - HL_W);

    localparam logic [ADDR_W-1:0] A_START = ADDR_W'(START_BASE);
    localparam logic [ADDR_W-1:0] A_BAN   = ADDR_W'(BANNER_BASE);
    // Bottom banner: BASE + (H-1-yb)*W + (W-1-x) == BASE + LCD_H*LCD_W - 1 - lin.
    // Modular ADDR_W arithmetic keeps the final result exact even if this constant wraps.
    localparam logic [ADDR_W-1:0] A_BOT   = ADDR_W'(BANNER_BASE + LCD_H*LCD_W - 1);
    localparam logic [ADDR_W-1:0] A_PIECE = ADDR_W'(PIECE_BASE);
    localparam logic [ADDR_W-1:0] A_PLANE = ADDR_W'(SQ*SQ*KINDS);
    localparam logic [ADDR_W-1:0] A_ROW   = ADDR_W'(SQ*KINDS);
    localparam logic [ADDR_W-1:0] A_SQ    = ADDR_W'(SQ);

    // S0 raster state: x/y plus incremental square-local counters and a linear
    // pixel index, so no divider or y*LCD_W multiplier is needed.
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [LW-1:0]     lx_q, lx_d, ly_q, ly_d;
    logic [XW-1:0]     col_q, col_d;
    logic [YW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] lin_q, lin_d;
    logic              play_active_q;

    // S1: tags travelling alongside the ROM read
    logic              s1_vld_q, s1_rom_q;
    logic [15:0]       s1_flat_q;
    logic [XW-1:0]     s1_x_q;
    logic [YW-1:0]     s1_y_q;

    // S2: output register
    logic              s2_vld_q;
    logic [15:0]       s2_data_q, s2_data_d;
    logic [XW-1:0]     s2_x_q;
    logic [YW-1:0]     s2_y_q;
    logic              frame_done_q;

    logic              advance;
    logic              view_play, in_top, in_bot, in_board, light, edge_px;
    logic              cur_hit, sel_hit, has_piece, use_rom;
    logic [SW-1:0]     sq_idx;
    logic [3:0]        sq_bits;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       flat;

    assign advance = !s2_vld_q || pixelReady;

    // Raster and square-local counter next state
    always_comb begin
        x_d   = x_q + 1'b1;
        y_d   = y_q;
        lx_d  = lx_q + 1'b1;
        col_d = col_q;
        ly_d  = ly_q;
        row_d = row_q;
        lin_d = lin_q + 1'b1;
        if (lx_q == SQ_LAST) begin
            lx_d  = '0;
            col_d = col_q + 1'b1;
        end
        if (x_q == X_LAST) begin
            x_d   = '0;
            lx_d  = '0;
            col_d = '0;
            y_d   = y_q + 1'b1;
            if (y_q == Y_LAST) begin
                y_d   = '0;
                ly_d  = '0;
                row_d = '0;
                lin_d = '0;
            end else if (y_q == Y_TOP_END) begin
                // next line is the first board line
                ly_d  = '0;
                row_d = '0;
            end else if (ly_q == SQ_LAST) begin
                ly_d  = '0;
                row_d = row_q + 1'b1;
            end else begin
                ly_d  = ly_q + 1'b1;
            end
        end
    end

    // S0 address generation / flat-colour decision
    always_comb begin
        // the frame's view is decided at (0,0) and used for that pixel already
        view_play = (x_q == '0 && y_q == '0) ? play_req : play_active_q;
        in_top    = y_q < Y_BRD0;
        in_bot    = y_q >= Y_BOT;
        in_board  = (col_q < COL_N) && (y_q >= Y_BRD0) && (y_q < Y_BRD_END);
        sq_idx    = in_board ? SW'(row_q * BOARD_N + col_q) : '0;
        sq_bits   = board[{sq_idx, 2'b00} +: 4];
        light     = ~(row_q[0] ^ col_q[0]);
        edge_px   = (lx_q < HL_LO) || (lx_q >= HL_HI) || (ly_q < HL_LO) || (ly_q >= HL_HI);
        cur_hit   = in_board && edge_px && (sq_idx == cursor_sq);
        sel_hit   = in_board && edge_px && select_vld && (sq_idx == select_sq);
        has_piece = (sq_bits[2:0] != 3'd0) && (sq_bits[2:0] != 3'd7);
        use_rom   = 1'b0;
        addr      = '0;
        flat      = DARK_COL;
        if (!view_play) begin
            use_rom = 1'b1;
            addr    = A_START + lin_q;
        end else if (in_top) begin
            use_rom = 1'b1;
            addr    = A_BAN + lin_q;
        end else if (in_bot) begin
            use_rom = 1'b1;
            addr    = A_BOT - lin_q;
        end else if (in_board) begin
            if (cur_hit) begin
                flat = CURSOR_COL;
            end else if (sel_hit) begin
                flat = SELECT_COL;
            end else if (has_piece) begin
                use_rom = 1'b1;
                addr    = A_PIECE
                        + ADDR_W'({sq_bits[3], light}) * A_PLANE
                        + ADDR_W'(ly_q) * A_ROW
                        + ADDR_W'(sq_bits[2:0] - 3'd1) * A_SQ
                        + ADDR_W'(lx_q);
            end else begin
                flat = light ? LIGHT_COL : DARK_COL;
            end
        end
    end

    // The ROM only moves on advance, so during a stall its output stays paired
    // with the S1 tags and is picked up intact when the stall clears.
    assign rom_en   = advance && use_rom && !reset;
    assign rom_addr = reset ? '0 : addr;

    always_comb begin
        s2_data_d = s1_rom_q ? rom_rdata : s1_flat_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            lx_q          <= '0;
            ly_q          <= '0;
            col_q         <= '0;
            row_q         <= '0;
            lin_q         <= '0;
            play_active_q <= 1'b0;
            s1_vld_q      <= 1'b0;
            s1_rom_q      <= 1'b0;
            s1_flat_q     <= '0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            s2_vld_q      <= 1'b0;
            s2_data_q     <= '0;
            s2_x_q        <= '0;
            s2_y_q        <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= s2_vld_q && pixelReady && (s2_x_q == X_LAST) && (s2_y_q == Y_LAST);
            if (advance) begin
                x_q   <= x_d;
                y_q   <= y_d;
                lx_q  <= lx_d;
                ly_q  <= ly_d;
                col_q <= col_d;
                row_q <= row_d;
                lin_q <= lin_d;
                if (x_q == '0 && y_q == '0) begin
                    play_active_q <= play_req;
                end
                s1_vld_q  <= 1'b1;
                s1_rom_q  <= use_rom;
                s1_flat_q <= flat;
                s1_x_q    <= x_q;
                s1_y_q    <= y_q;
                s2_vld_q  <= s1_vld_q;
                s2_data_q <= s2_data_d;
                s2_x_q    <= s1_x_q;
                s2_y_q    <= s1_y_q;
            end
        end
    end

    assign xAddr       = s2_x_q;
    assign yAddr       = s2_y_q;
    assign pixelData   = s2_data_q;
    assign pixelWrite  = s2_vld_q;
    assign play_active = play_active_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_board_frame_renderer.sv
// Directed bench. "m_" is the full-size panel (address and colour rules at the
// documented coordinates); "s_" is an 8x10 panel with a 2x2 board of 3 px squares
// so that whole frames, frame_done, view switching and mid-frame reset fit in a
// short run.
module tb_board_frame_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- full-size instance ----------------
    logic         m_reset, m_play, m_selv, m_romen, m_pw, m_rdy, m_pa, m_fd;
    logic [255:0] m_board;
    logic [5:0]   m_cur, m_sel;
    logic [16:0]  m_raddr;
    logic [15:0]  m_rdata, m_pd;
    logic [7:0]   m_x;
    logic [8:0]   m_y;

    board_frame_renderer u_main (
        .clock(clk), .reset(m_reset), .play_req(m_play), .board(m_board),
        .cursor_sq(m_cur), .select_sq(m_sel), .select_vld(m_selv),
        .rom_en(m_romen), .rom_addr(m_raddr), .rom_rdata(m_rdata),
        .xAddr(m_x), .yAddr(m_y), .pixelData(m_pd), .pixelWrite(m_pw),
        .pixelReady(m_rdy), .play_active(m_pa), .frame_done(m_fd)
    );

    // ---------------- small instance ----------------
    logic         s_reset, s_play, s_selv, s_romen, s_pw, s_rdy, s_pa, s_fd;
    logic [15:0]  s_board;
    logic [1:0]   s_cur, s_sel;
    logic [16:0]  s_raddr;
    logic [15:0]  s_rdata, s_pd;
    logic [2:0]   s_x;
    logic [3:0]   s_y;

    board_frame_renderer #(
        .LCD_W(8), .LCD_H(10), .BANNER_H(2), .BOARD_N(2), .SQ(3), .KINDS(6),
        .HL_W(1), .ADDR_W(17), .START_BASE(0), .BANNER_BASE(80), .PIECE_BASE(96)
    ) u_small (
        .clock(clk), .reset(s_reset), .play_req(s_play), .board(s_board),
        .cursor_sq(s_cur), .select_sq(s_sel), .select_vld(s_selv),
        .rom_en(s_romen), .rom_addr(s_raddr), .rom_rdata(s_rdata),
        .xAddr(s_x), .yAddr(s_y), .pixelData(s_pd), .pixelWrite(s_pw),
        .pixelReady(s_rdy), .play_active(s_pa), .frame_done(s_fd)
    );

    // Sprite ROM contents as a simple function of the address
    function automatic logic [15:0] rom_fn(input logic [16:0] a);
        return a[15:0] ^ {a[16], 15'h25C3};
    endfunction

    // synchronous ROMs: output only changes when enabled
    always @(posedge clk) if (m_romen) m_rdata <= rom_fn(m_raddr);
    always @(posedge clk) if (s_romen) s_rdata <= rom_fn(s_raddr);

    localparam logic [15:0] LIGHT  = 16'hEF9B;
    localparam logic [15:0] DARK   = 16'h7A69;
    localparam logic [15:0] CURSOR = 16'h07E0;
    localparam logic [15:0] SELECT = 16'hF800;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic m_wait_pix(input int px, input int py);
        logic found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (m_pw && int'(m_x) == px && int'(m_y) == py) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("m_seen_%0d_%0d", px, py), 32'(found), 32'd1);
    endtask

    task automatic s_wait_pix(input int px, input int py);
        logic found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_pw && int'(s_x) == px && int'(s_y) == py) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("s_seen_%0d_%0d", px, py), 32'(found), 32'd1);
    endtask

    initial begin
        int         cnt;
        logic       done;
        logic [2:0] lastx;
        logic [3:0] lasty;

        m_reset = 1'b1; m_play = 1'b1; m_rdy = 1'b1; m_board = '0;
        m_board[3:0] = 4'b0001;            // square 0: colour 0, kind 1
        m_cur = 6'd1; m_sel = 6'd0; m_selv = 1'b0;
        s_reset = 1'b1; s_play = 1'b0; s_rdy = 1'b1; s_board = '0;
        s_cur = 2'd3; s_sel = 2'd0; s_selv = 1'b0;

        // ---------------- small panel ----------------
        repeat (3) @(negedge clk);
        check("s_rst_pw",    32'(s_pw),    32'd0);
        check("s_rst_romen", 32'(s_romen), 32'd0);
        check("s_rst_fd",    32'(s_fd),    32'd0);
        check("s_rst_pa",    32'(s_pa),    32'd0);
        check("s_rst_pd",    32'(s_pd),    32'd0);

        s_reset = 1'b0;
        #1;
        check("s_c0_romen", 32'(s_romen), 32'd1);
        check("s_c0_addr",  32'(s_raddr), 32'd0);
        @(negedge clk);
        check("s_c1_pw", 32'(s_pw), 32'd0);
        @(negedge clk);
        check("s_c2_pw",   32'(s_pw),         32'd1);
        check("s_c2_xy",   32'({s_x, s_y}),   32'd0);
        check("s_c2_data", 32'(s_pd),         32'(rom_fn(17'd0)));

        // whole first frame; request play view part-way through
        cnt = 0; done = 1'b0; lastx = '0; lasty = '0;
        for (int i = 0; i < 200; i++) begin
            if (s_fd) begin
                done = 1'b1;
                break;
            end
            if (s_pw && s_rdy) begin
                cnt++;
                lastx = s_x;
                lasty = s_y;
                if (s_x == 3'd2 && s_y == 4'd5) s_play = 1'b1;
                if (s_x == 3'd3 && s_y == 4'd5) begin
                    check("s_mid_data", 32'(s_pd), 32'(rom_fn(17'd43)));
                    check("s_mid_pa",   32'(s_pa), 32'd0);
                end
            end
            @(negedge clk);
        end
        check("s_fd_seen",   32'(done),           32'd1);
        check("s_pix_count", 32'(cnt),            32'd80);
        check("s_last_xy",   32'({lastx, lasty}), 32'({3'd7, 4'd9}));
        // frame 2 first pixel is already on the outputs
        check("s_f2_pw",   32'(s_pw),       32'd1);
        check("s_f2_xy",   32'({s_x, s_y}), 32'd0);
        check("s_f2_pa",   32'(s_pa),       32'd1);
        check("s_f2_data", 32'(s_pd),       32'(rom_fn(17'd80)));
        @(negedge clk);
        check("s_fd_pulse", 32'(s_fd), 32'd0);

        s_wait_pix(1, 3);
        check("s_light_empty", 32'(s_pd), 32'(LIGHT));
        s_wait_pix(6, 3);
        check("s_outside", 32'(s_pd), 32'(DARK));
        s_wait_pix(5, 8);
        check("s_bot_5_8", 32'(s_pd), 32'(rom_fn(17'd90)));
        s_wait_pix(0, 9);
        check("s_bot_0_9", 32'(s_pd), 32'(rom_fn(17'd87)));

        // reset in the middle of the last line
        s_reset = 1'b1;
        s_play  = 1'b0;
        @(negedge clk);
        check("s_mrst_pw", 32'(s_pw), 32'd0);
        check("s_mrst_fd", 32'(s_fd), 32'd0);
        s_reset = 1'b0;
        @(negedge clk);
        check("s_rs1_pw", 32'(s_pw), 32'd0);
        @(negedge clk);
        check("s_rs2_pw",   32'(s_pw),       32'd1);
        check("s_rs2_xy",   32'({s_x, s_y}), 32'd0);
        check("s_rs2_pa",   32'(s_pa),       32'd0);
        check("s_rs2_data", 32'(s_pd),       32'(rom_fn(17'd0)));

        // ---------------- full-size panel ----------------
        check("m_rst_pw", 32'(m_pw), 32'd0);
        m_reset = 1'b0;
        m_wait_pix(0, 0);
        check("m_top_0_0", 32'(m_pd), 32'(rom_fn(17'd76800)));
        check("m_pa",      32'(m_pa), 32'd1);

        // back-pressure in the top banner row
        m_wait_pix(100, 20);
        check("m_pre_stall", 32'(m_pd), 32'(rom_fn(17'd81700)));
        m_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("m_stall_pw",    32'(m_pw),    32'd1);
            check("m_stall_x",     32'(m_x),     32'd100);
            check("m_stall_data",  32'(m_pd),    32'(rom_fn(17'd81700)));
            check("m_stall_romen", 32'(m_romen), 32'd0);
        end
        m_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("m_post_pw",   32'(m_pw), 32'd1);
            check("m_post_x",    32'(m_x),  32'(100 + k));
            check("m_post_y",    32'(m_y),  32'd20);
            check("m_post_data", 32'(m_pd), 32'(rom_fn(17'(81700 + k))));
        end

        m_wait_pix(5, 47);
        check("m_piece", 32'(m_pd), 32'(rom_fn(17'd93065)));
        m_wait_pix(30, 60);
        check("m_cursor", 32'(m_pd), 32'(CURSOR));
        m_wait_pix(40, 60);
        check("m_dark_empty", 32'(m_pd), 32'(DARK));
        m_selv = 1'b1;
        m_sel  = 6'd1;
        m_wait_pix(30, 61);
        check("m_cursor_wins", 32'(m_pd), 32'(CURSOR));
        m_cur = 6'd0;
        m_wait_pix(30, 62);
        check("m_select", 32'(m_pd), 32'(SELECT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
